// File: rtl/sync_filter_pkg.sv
// Shared constants and helpers for the sync_filter input conditioner.
package sync_filter_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int FILTER_LEN_MIN  = 1;
  localparam int FILTER_LEN_MAX  = 65535;

  // Stability counter width; a single bit when FILTER_LEN is 1.
  function automatic int cnt_width(input int filter_len);
    return (filter_len > 1) ? $clog2(filter_len) : 1;
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: synchroniser chain, stability counter, filtered level and edge pulses.
module sync_filter_ch
  import sync_filter_pkg::*;
#(
  parameter int   STAGES     = 2,
  parameter int   FILTER_LEN = 1,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic data_i,
  output logic data_o,
  output logic rise_o,
  output logic fall_o,
  output logic update_o
);

  localparam int               CNT_W    = cnt_width(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [STAGES-1:0] sync_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              synced;

  assign synced = sync_q[STAGES-1];

  // High in the cycle before data_o takes the synced value; feeds the top's change flop.
  assign update_o = (synced != data_o) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the sync chain is reset to the channel's reset level too, so release
      // cannot flush a stale value through and fake an edge.
      sync_q <= {STAGES{RESET_VAL}};
      cnt_q  <= '0;
      data_o <= RESET_VAL;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every stage samples the previous cycle's value.
      sync_q <= {sync_q[STAGES-2:0], data_i};
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      if (synced == data_o) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        data_o <= synced;
        cnt_q  <= '0;
        rise_o <= synced;
        fall_o <= ~synced;
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/sync_filter.sv
// Multi-channel synchroniser with per-channel stability filter and edge pulses.
module sync_filter
  import sync_filter_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 2,
  parameter int               FILTER_LEN  = 1,
  parameter logic [WIDTH-1:0] RESET_STATE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             change_o
);

  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sync_filter: STAGES=%0d outside %0d..%0d", STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  end

  if (FILTER_LEN < FILTER_LEN_MIN || FILTER_LEN > FILTER_LEN_MAX) begin : g_bad_filter_len
    $error("sync_filter: FILTER_LEN=%0d outside %0d..%0d", FILTER_LEN, FILTER_LEN_MIN, FILTER_LEN_MAX);
  end

  logic [WIDTH-1:0] update;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_filter_ch #(
      .STAGES     (STAGES),
      .FILTER_LEN (FILTER_LEN),
      .RESET_VAL  (RESET_STATE[i])
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .data_i   (data_i[i]),
      .data_o   (data_o[i]),
      .rise_o   (rise_o[i]),
      .fall_o   (fall_o[i]),
      .update_o (update[i])
    );
  end

  // Registered from the channels' next-cycle update flags so it lines up with the pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      change_o <= 1'b0;
    end else begin
      change_o <= |update;
    end
  end

endmodule

// File: doc/sync_filter.md
# sync_filter

Parametrised multi-channel input conditioner. It brings WIDTH asynchronous single-bit signals into the clk domain through a STAGES-deep flop chain, then applies a per-channel stability filter. The filter only updates the output after the synchronised value has held constant for FILTER_LEN consecutive cycles, and it emits registered one-cycle rise/fall pulses. It sits at the boundary between external or foreign-domain status/control bits and the core control FSMs, replacing bare two-flop chains where debounce or edge events are needed.

## Interface
Parameters:
- WIDTH, 1, number of independent channels.
- STAGES, 2, synchroniser depth; legal range 2..4.
- FILTER_LEN, 1, required stable cycles before an output update; legal range 1..65535. A value of 1 means no filtering.
- RESET_STATE, {WIDTH{1'b0}}, per-channel reset value (WIDTH-bit vector).

Ports:
- clk  input  1  single clock; all logic is on posedge.
- reset  input  1  asynchronous, active-high reset.
- data_i  input  WIDTH  asynchronous channel inputs.
- data_o  output  WIDTH  filtered, synchronised level per channel.
- rise_o  output  WIDTH  one-cycle pulse when data_o[i] goes 0→1.
- fall_o  output  WIDTH  one-cycle pulse when data_o[i] goes 1→0.
- change_o  output  1  registered OR of all rise/fall pulses, asserted in the same cycle as those pulses.

## Operation
- Sync chain, per channel: s0 ← data_i[i], s1 ← s0, …, s(STAGES−1). The synced value s is the last stage of the chain.
- Each channel has a filter counter cnt of width $clog2(FILTER_LEN) (minimum 1 bit).
- Each cycle, per channel:
  - If s == data_o[i]: cnt ← 0; no pulse.
  - Else if cnt == FILTER_LEN−1: data_o[i] ← s; cnt ← 0; rise_o[i] ← s, fall_o[i] ← ~s.
  - Else: cnt ← cnt+1; data_o[i] holds.
- rise_o and fall_o default to 0 in every cycle that has no update. They are never both high on the same channel.
- Bounce handling: any return of s to data_o[i] before the count completes clears cnt. The partial count is discarded, not held.
- Channels are fully independent. Simultaneous updates on several channels produce simultaneous pulses, and change_o is high for that single cycle.
- Reset, whether at power-up or mid-operation, takes effect immediately and asynchronously:
  - all sync stages and data_o ← RESET_STATE;
  - cnt ← 0;
  - rise_o, fall_o, change_o ← 0.
  - The first pulse after reset release can only come from a genuine difference from RESET_STATE.
- No X propagation: counters never wrap, because cnt saturates by construction (it is cleared at FILTER_LEN−1).

## Timing
- Latency from data_i change (sampled at edge 1) to data_o update is STAGES+FILTER_LEN edges. With STAGES=2, FILTER_LEN=1 the update lands on edge 3.
- rise_o/fall_o/change_o assert on the same edge as the data_o update, for exactly one cycle.
- A pulse on data_i shorter than FILTER_LEN cycles (after synchronisation) is suppressed entirely.
- Back-to-back toggles are supported: the minimum spacing between two output updates on one channel is FILTER_LEN cycles.
- All outputs are driven directly from flops; there are no combinational paths from input to output.

## Structure
- The shared package/header holds:
  - the STAGES legal-range constants (SYNC_STAGES_MIN=2, SYNC_STAGES_MAX=4);
  - a clog2-derived counter-width helper used by the filter.
- One sub-module, sync_filter_ch: a single channel containing its sync chain, counter, data_o bit and rise/fall flops.
  - The top generates it WIDTH times and ORs the pulses into the change_o flop input.
- Parameter range violations are caught by elaboration-time checks in the top.

## Test plan
- Reset values:
  - Stimulus: WIDTH=4, RESET_STATE=4'b1010, hold reset while data_i=4'b0101.
  - Required: data_o=4'b1010 and all pulses 0 during reset.
  - After release: data_o becomes 4'b0101 on edge STAGES+1, rise_o=4'b0101, fall_o=4'b1010, change_o=1 for one cycle.
- Plain-synchroniser latency:
  - Stimulus: STAGES=3, FILTER_LEN=1, data_i[0] 0→1 before edge n.
  - Required: data_o[0]=1 and rise_o[0]=1 at edge n+3, rise_o[0]=0 at edge n+4.
- Glitch rejection:
  - Stimulus: FILTER_LEN=8, data_i[0] high for 7 cycles then low.
  - Required: data_o[0] stays 0, no pulses.
  - Repeat with 8 cycles high: data_o[0]=1 exactly STAGES+8 edges after the rise, one rise pulse.
- Bounce restart:
  - Stimulus: FILTER_LEN=4, pattern 1,1,1,0,1,1,1,1 on data_i[1].
  - Required: the update occurs 4 cycles after the final 0→1, not earlier; a single rise pulse.
- Simultaneous channels and mid-operation reset:
  - Stimulus: all channels toggle together.
  - Required: rise_o=all-ones and change_o=1 in the same single cycle.
  - Then assert reset while the count is at FILTER_LEN−2: outputs return immediately to RESET_STATE/0, and no pulse fires after release until a full new count completes.
